cmsdk_mcu_mtx_arb_rr: RTL and testbench
=======================================

// Module: cmsdk_mcu_mtx_arb_rr
// PURPOSE
//  Round-robin output-stage arbiter for one slave port of the MCU AHB bus matrix.
//  Chooses which input port drives the shared slave's address phase.
//  Tracks fixed-length bursts so that ownership does not change mid-burst.
//  Sits between the input-stage request lines and the output-stage address mux; drop-in alternative to the fixed-priority arbiters.
// PARAMETERS
//  NUM_PORTS  4  number of input ports competing for this slave (2..8)
//  PORT_W     2  width of port index; must equal clog2(NUM_PORTS)
//  BURST_HOLD 1  1: hold grant for the remaining beats of INCR4/8/16 and WRAP4/8/16; 0: re-arbitrate every beat
// PORTS
//  HCLK        in   1          AHB system clock
//  HRESETn     in   1          reset: synchronous, active-low
//  req_port    in   NUM_PORTS  per-port request; bit i = port i wants the slave
//  HREADYM     in   1          slave-side transfer done; all state advances only when 1
//  HSELM       in   1          slave select of the transfer in address phase
//  HTRANSM     in   2          transfer type of the current owner
//  HBURSTM     in   3          burst type of the current owner
//  HMASTLOCKM  in   1          locked transfer in progress
//  addr_in_port out PORT_W     registered index of the port owning the address phase
//  no_port     out  1          registered; 1 = no port selected, mux drives IDLE
//  burst_hold  out  1          registered; 1 = grant frozen by burst tracking
// BEHAVIOUR
//  Reset (HRESETn=0 sampled at posedge HCLK):
//   - no_port=1, addr_in_port=0, burst_hold=0, beat_cnt=0.
//   - last_grant=NUM_PORTS-1, so port 0 wins first.
//  Update rule: registers load only on posedge HCLK with HREADYM=1. With HREADYM=0 every register holds.
//  Beat counter (4 bits), next value beat_nxt computed from the current address phase (HSELM=1):
//   - NONSEQ: load 3 for HBURSTM 2/3, 7 for 4/5, 15 for 6/7; 0 for SINGLE(0) or INCR(1).
//   - SEQ: beat_cnt-1, saturating at 0.
//   - BUSY: hold.
//   - IDLE: clear to 0 (early burst termination).
//   - HSELM=0: clear to 0.
//   - BURST_HOLD=0: beat_nxt is forced to 0.
//  Combinational decision, first matching rule wins:
//   1. HMASTLOCKM=1: keep addr_in_port, no_port=0.
//   2. beat_nxt!=0: keep addr_in_port, no_port=0, burst_hold=1.
//   3. Effective requests exist: eff = req_port | (onehot(addr_in_port) & {NUM_PORTS{HSELM & HTRANSM!=IDLE & ~no_port}}).
//      - Grant the first set bit of eff, scanning from last_grant+1 upward and wrapping modulo NUM_PORTS.
//      - last_grant <= winner, no_port=0.
//   4. No effective requests, HSELM=1: keep addr_in_port, no_port=0.
//   5. Otherwise: no_port=1, addr_in_port holds its old value.
//  burst_hold = 1 only under rule 2, else 0.
//  last_grant changes only under rule 3.
//  Fairness bound: a port requesting continuously is granted within NUM_PORTS-1 other grants, provided locks and bursts complete.
//  Simultaneous events:
//   - Lock overrides burst tracking and new requests.
//   - A NONSEQ arriving while beat_cnt!=0 reloads the counter (new burst by the same owner).
//  Reset mid-burst or mid-lock: all state returns to reset values on that edge; no partial hold survives.
//  Latency: request to grant is one HREADYM-qualified HCLK edge.
// STRUCTURE
//  Package cmsdk_mtx_arb_pkg holds:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ (2'b00/01/10/11).
//   - HBURST_* encodings (3'b000..3'b111).
//   - function burst_len_m1(hburst) returning 0/3/7/15.
//  Sub-module cmsdk_mtx_rr_pick: combinational rotating priority encoder.
//   - Inputs: eff[NUM_PORTS], last_grant.
//   - Outputs: winner[PORT_W], any.
//  Top level holds beat_cnt, the decision mux and the output registers.
// TESTING
//  T1 reset: HRESETn=0 for 2 cycles -> no_port=1, addr_in_port=0, burst_hold=0. Release; req_port=4'b1111, HREADYM=1 -> next edge addr_in_port=0.
//  T2 rotation: req_port=4'b1111, owner issues SINGLE NONSEQ each beat -> addr_in_port sequence 0,1,2,3,0.
//  T3 burst hold: port 1 issues INCR4 NONSEQ+3 SEQ while req_port[0]=1 -> addr_in_port stays 1 for 4 beats with burst_hold=1 on beats 1-3; then moves to 2 if req_port[2]=1, else 3 if req_port[3]=1, else wraps to 0.
//  T4 early termination/BUSY: WRAP8 NONSEQ, 2 SEQ, 1 BUSY (counter holds at 5), then IDLE -> beat_cnt=0; next edge re-arbitrates to the next requester.
//  T5 lock and wait: HMASTLOCKM=1 with req_port=4'b1110 and owner 0 -> addr_in_port=0 for the whole lock; HREADYM=0 for 3 cycles -> all outputs frozen.
//  T6 no port: req_port=0, HSELM=0 -> no_port=1 next edge, addr_in_port unchanged. Then req_port[3]=1 -> addr_in_port=3, no_port=0.

Source files
------------

// File: rtl/cmsdk_mcu_mtx_arb_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_mtx_arb_pkg
// Brief    : AHB encodings and burst-length helper for the round-robin arbiter
// Revision : 1.0
// ============================================================================
package cmsdk_mtx_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Beats still to come after the NONSEQ beat; undefined-length bursts get 0.
    function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmsdk_mcu_mtx_arb_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_mcu_mtx_arb_rr_if
// Brief    : Request/address-phase bundle between input stage and arbiter
// Revision : 1.0
// ============================================================================
interface cmsdk_mcu_mtx_arb_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );
endinterface
`default_nettype wire

// File: rtl/cmsdk_mcu_mtx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_mtx_rr_pick
// Brief    : Rotating priority encoder, search starts just above last_grant
// Revision : 1.0
// ============================================================================
module cmsdk_mtx_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  wire logic [NUM_PORTS-1:0] eff_i,
    input  wire logic [PORT_W-1:0]    last_grant_i,
    output logic      [PORT_W-1:0]    winner_o,
    output logic                      any_o
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int idx;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % NUM_PORTS;
            if (eff_i[idx]) begin
                winner_o = PORT_W'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmsdk_mcu_mtx_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_mcu_mtx_arb_rr
// Brief    : Round-robin output-stage arbiter with fixed-length burst tracking
// Revision : 1.0
// ============================================================================
module cmsdk_mcu_mtx_arb_rr
    import cmsdk_mtx_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = 2,
    parameter int BURST_HOLD = 1
) (
    input wire logic         HCLK,
    input wire logic         HRESETn,
    cmsdk_mcu_mtx_arb_rr_if.slave bus
);

    logic [PORT_W-1:0]    addr_q, addr_d;
    logic [PORT_W-1:0]    last_q, last_d;
    logic                 no_port_q, no_port_d;
    logic                 hold_q, hold_d;
    logic [3:0]           beat_q, beat_d;

    logic [NUM_PORTS-1:0] w_eff;
    logic [NUM_PORTS-1:0] w_own;
    logic [PORT_W-1:0]    w_winner;
    logic                 w_any;
    logic                 w_owner_active;

    always_comb begin
        beat_d = 4'd0;
        if ((BURST_HOLD != 0) && bus.HSELM) begin
            case (bus.HTRANSM)
                HTRANS_NONSEQ: beat_d = burst_len_m1(bus.HBURSTM);
                HTRANS_SEQ:    beat_d = (beat_q != 4'd0) ? (beat_q - 4'd1) : 4'd0;
                HTRANS_BUSY:   beat_d = beat_q;
                default:       beat_d = 4'd0;
            endcase
        end
    end

    // The current owner keeps competing while it still has a live transfer.
    assign w_owner_active = bus.HSELM && (bus.HTRANSM != HTRANS_IDLE) && !no_port_q;
    assign w_own          = NUM_PORTS'(1) << addr_q;
    assign w_eff          = bus.req_port | (w_own & {NUM_PORTS{w_owner_active}});

    cmsdk_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .eff_i        (w_eff),
        .last_grant_i (last_q),
        .winner_o     (w_winner),
        .any_o        (w_any)
    );

    always_comb begin
        addr_d    = addr_q;
        last_d    = last_q;
        no_port_d = 1'b0;
        hold_d    = 1'b0;
        if (bus.HMASTLOCKM) begin
            no_port_d = 1'b0;
        end else if (beat_d != 4'd0) begin
            hold_d    = 1'b1;
        end else if (w_any) begin
            addr_d    = w_winner;
            last_d    = w_winner;
        end else if (bus.HSELM) begin
            no_port_d = 1'b0;
        end else begin
            no_port_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            last_q    <= PORT_W'(NUM_PORTS - 1);
            no_port_q <= 1'b1;
            hold_q    <= 1'b0;
            beat_q    <= 4'd0;
        end else if (bus.HREADYM) begin
            addr_q    <= addr_d;
            last_q    <= last_d;
            no_port_q <= no_port_d;
            hold_q    <= hold_d;
            beat_q    <= beat_d;
        end
    end

    assign bus.addr_in_port = addr_q;
    assign bus.no_port      = no_port_q;
    assign bus.burst_hold   = hold_q;

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_mcu_mtx_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmsdk_mcu_mtx_arb_rr
// Brief    : Directed vector table, reset sequence and random run vs. model
// Revision : 1.0
// ============================================================================
module tb_cmsdk_mcu_mtx_arb_rr;

    localparam int N = 4;

    typedef struct {
        bit       rstn;
        bit [3:0] req;
        bit       rdy;
        bit       sel;
        bit [1:0] trans;
        bit [2:0] burst;
        bit       lock;
        bit [1:0] ea;
        bit       en;
        bit       eh;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    cmsdk_mcu_mtx_arb_rr_if #(.NUM_PORTS(N), .PORT_W(2)) bus_if ();

    cmsdk_mcu_mtx_arb_rr #(
        .NUM_PORTS  (N),
        .PORT_W     (2),
        .BURST_HOLD (1)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    int m_owner = 0;
    int m_last  = N - 1;
    int m_beats = 0;
    bit m_nop   = 1'b1;
    bit m_hold  = 1'b0;

    vec_t tbl[30];
    vec_t hs[6];

    function automatic vec_t mk(bit rstn, bit [3:0] req, bit rdy, bit sel, bit [1:0] trans,
                                bit [2:0] burst, bit lock, bit [1:0] ea, bit en, bit eh);
        vec_t v;
        v.rstn = rstn; v.req = req; v.rdy = rdy; v.sel = sel; v.trans = trans;
        v.burst = burst; v.lock = lock; v.ea = ea; v.en = en; v.eh = eh;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Beat count and grant decision derived directly from the AHB burst rules.
    task automatic model_step(vec_t v);
        int  nb;
        int  win;
        bit  any;
        if (!v.rstn) begin
            m_owner = 0; m_last = N - 1; m_beats = 0; m_nop = 1'b1; m_hold = 1'b0;
            return;
        end
        if (!v.rdy) return;
        nb = 0;
        if (v.sel) begin
            case (v.trans)
                2'd2: nb = (v.burst < 3'd2) ? 0 : ((4 << ((int'(v.burst) - 2) / 2)) - 1);
                2'd3: nb = (m_beats > 0) ? m_beats - 1 : 0;
                2'd1: nb = m_beats;
                default: nb = 0;
            endcase
        end
        any = 1'b0;
        win = 0;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (!any && (v.req[p] || (p == m_owner && v.sel && v.trans != 2'd0 && !m_nop))) begin
                any = 1'b1;
                win = p;
            end
        end
        m_hold = 1'b0;
        if (v.lock) begin
            m_nop = 1'b0;
        end else if (nb != 0) begin
            m_nop = 1'b0; m_hold = 1'b1;
        end else if (any) begin
            m_owner = win; m_last = win; m_nop = 1'b0;
        end else if (v.sel) begin
            m_nop = 1'b0;
        end else begin
            m_nop = 1'b1;
        end
        m_beats = nb;
    endtask

    task automatic run_cycle(vec_t v);
        HRESETn            = v.rstn;
        bus_if.req_port    = v.req;
        bus_if.HREADYM     = v.rdy;
        bus_if.HSELM       = v.sel;
        bus_if.HTRANSM     = v.trans;
        bus_if.HBURSTM     = v.burst;
        bus_if.HMASTLOCKM  = v.lock;
        model_step(v);
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_vec(string tag, int i, vec_t v);
        check($sformatf("%s[%0d].addr_in_port", tag, i), int'(bus_if.addr_in_port), int'(v.ea));
        check($sformatf("%s[%0d].no_port", tag, i), int'(bus_if.no_port), int'(v.en));
        check($sformatf("%s[%0d].burst_hold", tag, i), int'(bus_if.burst_hold), int'(v.eh));
    endtask

    initial begin
        // reset, rotation
        tbl[0]  = mk(0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 4'hF, 1, 1, 2, 0, 0, 1, 0, 0);
        tbl[4]  = mk(1, 4'hF, 1, 1, 2, 0, 0, 2, 0, 0);
        tbl[5]  = mk(1, 4'hF, 1, 1, 2, 0, 0, 3, 0, 0);
        tbl[6]  = mk(1, 4'hF, 1, 1, 2, 0, 0, 0, 0, 0);
        // INCR4 by port 1 with port 0 requesting
        tbl[7]  = mk(1, 4'h3, 1, 1, 2, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1, 4'h3, 1, 1, 2, 3, 0, 1, 0, 1);
        tbl[9]  = mk(1, 4'h3, 1, 1, 3, 3, 0, 1, 0, 1);
        tbl[10] = mk(1, 4'h3, 1, 1, 3, 3, 0, 1, 0, 1);
        tbl[11] = mk(1, 4'h3, 1, 1, 3, 3, 0, 0, 0, 0);
        // WRAP8, BUSY holds, IDLE terminates early
        tbl[12] = mk(1, 4'h5, 1, 1, 2, 4, 0, 0, 0, 1);
        tbl[13] = mk(1, 4'h5, 1, 1, 3, 4, 0, 0, 0, 1);
        tbl[14] = mk(1, 4'h5, 1, 1, 3, 4, 0, 0, 0, 1);
        tbl[15] = mk(1, 4'h5, 1, 1, 1, 4, 0, 0, 0, 1);
        tbl[16] = mk(1, 4'h5, 1, 1, 0, 4, 0, 2, 0, 0);
        // lock held by port 0, then wait states
        tbl[17] = mk(1, 4'h1, 1, 1, 2, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 4'hE, 1, 1, 2, 0, 1, 0, 0, 0);
        tbl[19] = mk(1, 4'hE, 1, 1, 2, 0, 1, 0, 0, 0);
        tbl[20] = mk(1, 4'hE, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 4'hE, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[22] = mk(1, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 4'hE, 1, 1, 2, 0, 0, 1, 0, 0);
        // no port, wake-up on port 3, owner keep rules
        tbl[24] = mk(1, 4'h0, 1, 0, 0, 0, 0, 1, 1, 0);
        tbl[25] = mk(1, 4'h8, 1, 0, 0, 0, 0, 3, 0, 0);
        tbl[26] = mk(1, 4'h0, 1, 1, 2, 0, 0, 3, 0, 0);
        tbl[27] = mk(1, 4'h0, 1, 1, 0, 0, 0, 3, 0, 0);
        tbl[28] = mk(1, 4'h0, 1, 0, 0, 0, 0, 3, 1, 0);
        tbl[29] = mk(1, 4'h0, 1, 1, 0, 0, 0, 3, 0, 0);

        // reset in the middle of an INCR16
        hs[0] = mk(0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 0);
        hs[1] = mk(1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0);
        hs[2] = mk(1, 4'h0, 1, 1, 2, 7, 0, 0, 0, 1);
        hs[3] = mk(1, 4'h0, 1, 1, 3, 7, 0, 0, 0, 1);
        hs[4] = mk(0, 4'h0, 1, 1, 3, 7, 0, 0, 1, 0);
        hs[5] = mk(1, 4'h4, 1, 1, 3, 7, 0, 2, 0, 0);

        for (int i = 0; i < 30; i++) begin
            run_cycle(tbl[i]);
            check_vec("tbl", i, tbl[i]);
        end

        for (int i = 0; i < 6; i++) begin
            run_cycle(hs[i]);
            check_vec("rst_mid_burst", i, hs[i]);
        end

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk(1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
            v.rstn  = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            v.rdy   = v.rstn ? ($urandom_range(0, 3) != 0) : 1'b1;
            v.req   = 4'($urandom);
            v.sel   = ($urandom_range(0, 7) != 0);
            v.trans = 2'($urandom);
            v.burst = 3'($urandom);
            v.lock  = ($urandom_range(0, 11) == 0);
            run_cycle(v);
            check($sformatf("rnd[%0d].addr_in_port", i), int'(bus_if.addr_in_port), m_owner);
            check($sformatf("rnd[%0d].no_port", i), int'(bus_if.no_port), int'(m_nop));
            check($sformatf("rnd[%0d].burst_hold", i), int'(bus_if.burst_hold), int'(m_hold));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
